mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multi-cycle main control FSM for the modified MIPS32 core. It sequences the shared datapath (one memory port, one ALU, the register file and PC) across fetch, decode, execute, memory and writeback. It drives the 2-bit ALUOp consumed by the ALU control decoder and reacts to that decoder's `jr` flag. Memory accesses use a ready handshake, so the FSM tolerates wait states.

## Interface
- No parameters. State encoding and opcodes are fixed.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `opcode` input 6: instruction [31:26] from the IR. Valid from DECODE onward.
- `jr` input 1: from ALU control. Sampled only in EXEC.
- `zero` input 1: ALU zero flag. Sampled only in BRANCH.
- `mem_ready` input 1: memory completed the access this cycle.
- `aluop` output 2: to ALU control. 00 = add, 01 = sub, 10 = funct, 11 = or.
- `alu_src_a` output 1: 0 = PC, 1 = rs.
- `alu_src_b` output 2: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2. For ori, the datapath zero-extends.
- `pc_src` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs.
- `pc_write` output 1: PC load enable.
- `ir_write` output 1: IR load enable.
- `iord` output 1: memory address source. 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `reg_write` output 1: register file write enable.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `mem_to_reg` output 1: 0 = ALUOut, 1 = MDR.
- `illegal_op` output 1: one-cycle pulse on an undecodable opcode.
- `state` output 4: current state, for debug and the bench.

## Operation
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, bne = 000101, ori = 001101, j = 000010.
- All outputs are Moore functions of `state`, with two exceptions: handshake qualifiers use `mem_ready`, and the branch `pc_write` uses `zero` and `opcode`.
- Every output not listed for a state is 0.
- FETCH (0): `mem_read` = 1, `iord` = 0, `alu_src_a` = 0, `alu_src_b` = 01, `aluop` = 00, `pc_src` = 00.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Go to DECODE when `mem_ready`; otherwise stay.
- DECODE (1): `alu_src_a` = 0, `alu_src_b` = 11, `aluop` = 00 (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR.
  - R → EXEC.
  - beq/bne → BRANCH.
  - ori → IEXEC.
  - j → JUMP.
  - Any other opcode → FETCH with `illegal_op` = 1.
- MEMADR (2): `alu_src_a` = 1, `alu_src_b` = 10, `aluop` = 00. lw → MEMRD, sw → MEMWR.
- MEMRD (3): `mem_read` = 1, `iord` = 1. Go to MEMWB when `mem_ready`; otherwise stay.
- MEMWB (4): `reg_write` = 1, `reg_dst` = 0, `mem_to_reg` = 1. Then → FETCH.
- MEMWR (5): `mem_write` = 1, `iord` = 1. Go to FETCH when `mem_ready`; otherwise stay.
- EXEC (6): `alu_src_a` = 1, `alu_src_b` = 00, `aluop` = 10.
  - If `jr` = 1 → JRET.
  - Else → RWB.
- RWB (7): `reg_write` = 1, `reg_dst` = 1, `mem_to_reg` = 0. Then → FETCH.
- BRANCH (8): `alu_src_a` = 1, `alu_src_b` = 00, `aluop` = 01, `pc_src` = 01.
  - `pc_write` = `zero` XOR (`opcode` == bne).
  - Then → FETCH.
- IEXEC (9): `alu_src_a` = 1, `alu_src_b` = 10, `aluop` = 11. Then → IWB.
- IWB (10): `reg_write` = 1, `reg_dst` = 0, `mem_to_reg` = 0. Then → FETCH.
- JUMP (11): `pc_src` = 10, `pc_write` = 1. Then → FETCH.
- JRET (12): `pc_src` = 11, `pc_write` = 1, no register write. Then → FETCH.
- Encodings 13–15 are unreachable. If entered, they act like FETCH-idle (all outputs 0) and go to FETCH next cycle.

## Timing
- `rst_n` low forces `state` = FETCH asynchronously. While reset is held, every output is 0 except the FETCH Moore outputs (`mem_read` = 1, `alu_src_b` = 01).
  - `pc_write` and `ir_write` are gated to 0 during reset regardless of `mem_ready`.
- Reset asserted mid-instruction aborts it immediately. No partial `reg_write` or `mem_write` occurs after the asynchronous edge.
- Cycles per instruction with zero wait states:
  - lw 5; sw 4; R 4; jr 4; ori 4; beq/bne 3; j 3; illegal 2.
  - Each memory wait cycle adds 1.
- `mem_ready` is held in the requesting state. `mem_read`/`mem_write` stay asserted until the cycle `mem_ready` = 1. The address source (`iord`) is stable throughout.
- A `mem_ready` pulse in a non-memory state is ignored.
- `illegal_op` is high exactly one cycle (the DECODE cycle).

## Test plan
- Reset mid-MEMRD: assert `rst_n` = 0 → `state` = 0 immediately, `reg_write` = 0. Release with `mem_ready` = 1 → `state` 0→1 on the next edge.
- lw (`opcode` = 100011), `mem_ready` = 1 always:
  - States 0,1,2,3,4,0.
  - `aluop` sequence 00,00,00,00,00.
  - `reg_write` = 1 only in state 4, with `mem_to_reg` = 1.
- sw with `mem_ready` low for 2 cycles in MEMWR:
  - States 0,1,2,5,5,5,0.
  - `mem_write` = 1 for 3 cycles, `iord` = 1.
- R-type add: `aluop` = 10 in EXEC, `jr` = 0 → RWB with `reg_dst` = 1.
- R-type jr: `jr` = 1 in EXEC → `state` 12, `pc_src` = 11, `pc_write` = 1, `reg_write` = 0.
- Branches:
  - beq with `zero` = 1: `pc_write` = 1, `aluop` = 01.
  - bne with `zero` = 1: `pc_write` = 0.
  - Illegal opcode 111111: `illegal_op` = 1 for one cycle, then `state` = 0.

Source files
------------

// File: rtl/mips_mc_controller.sv
// Multi-cycle main control FSM for the MIPS32 core: sequences fetch, decode, execute, memory
// and writeback over a shared datapath, with ready-handshaked memory accesses.
module mips_mc_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       jr,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] aluop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpBne = 6'b000101;
  localparam logic [5:0] OpOri = 6'b001101;
  localparam logic [5:0] OpJ   = 6'b000010;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StIexec  = 4'd9,
    StIwb    = 4'd10,
    StJump   = 4'd11,
    StJret   = 4'd12
  } state_e;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write_u;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  // Moore outputs for a state; computed from the next state so they register in step with it.
  function automatic ctrl_t decode_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      StDecode: c.alu_src_b = 2'b11;
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      StMemRd: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      StMemWb: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      StExec: begin
        c.alu_src_a = 1'b1;
        c.aluop     = 2'b10;
      end
      StRwb: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      StBranch: begin
        c.alu_src_a = 1'b1;
        c.aluop     = 2'b01;
        c.pc_src    = 2'b01;
      end
      StIexec: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.aluop     = 2'b11;
      end
      StIwb: c.reg_write = 1'b1;
      StJump: begin
        c.pc_src     = 2'b10;
        c.pc_write_u = 1'b1;
      end
      StJret: begin
        c.pc_src     = 2'b11;
        c.pc_write_u = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   op_valid;

  always_comb begin
    op_valid = 1'b0;
    case (opcode)
      OpR, OpLw, OpSw, OpBeq, OpBne, OpOri, OpJ: op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLw, OpSw:   state_d = StMemAdr;
          OpR:          state_d = StExec;
          OpBeq, OpBne: state_d = StBranch;
          OpOri:        state_d = StIexec;
          OpJ:          state_d = StJump;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
      StExec:   state_d = jr ? StJret : StRwb;
      StIexec:  state_d = StIwb;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      ctrl_q  <= decode_ctrl(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  logic in_fetch, in_branch;
  assign in_fetch  = (state_q == StFetch);
  assign in_branch = (state_q == StBranch);

  assign aluop      = ctrl_q.aluop;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_src     = ctrl_q.pc_src;
  assign iord       = ctrl_q.iord;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign state      = state_q;

  // Load enables are qualified by rst_n so a held reset never updates PC or IR.
  assign ir_write   = rst_n & in_fetch & mem_ready;
  assign pc_write   = rst_n & (ctrl_q.pc_write_u | (in_fetch & mem_ready) |
                               (in_branch & (zero ^ (opcode == OpBne))));
  assign illegal_op = (state_q == StDecode) & ~op_valid;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class through its state
// sequence and checks the control outputs against hand-computed values.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       jr = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [1:0] aluop, alu_src_b, pc_src;
  logic       alu_src_a, pc_write, ir_write, iord, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [3:0] state;

  int errs = 0;
  int checks = 0;

  mips_mc_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .jr         (jr),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .aluop      (aluop),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    checks++; if (state !== 4'd0) begin errs++; $display("FAIL rst_state: got %0d want 0", state); end
    checks++; if (mem_read !== 1'b1) begin errs++; $display("FAIL rst_mem_read: got %b want 1", mem_read); end
    checks++; if (alu_src_b !== 2'b01) begin errs++; $display("FAIL rst_alu_src_b: got %b want 01", alu_src_b); end
    checks++; if (pc_write !== 1'b0 || ir_write !== 1'b0) begin
      errs++; $display("FAIL rst_gate: pc_write=%b ir_write=%b want 0 0", pc_write, ir_write);
    end
    checks++; if ({aluop, iord, reg_write, mem_write} !== 5'b0) begin
      errs++; $display("FAIL rst_others: got %b want 00000", {aluop, iord, reg_write, mem_write});
    end
    opcode = 6'b100011;
    rst_n = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1 || ir_write !== 1'b1) begin
      errs++; $display("FAIL fetch_ready: pc_write=%b ir_write=%b want 1 1", pc_write, ir_write);
    end
    tick();
    checks++; if (state !== 4'd1) begin errs++; $display("FAIL rst_release: got %0d want 1", state); end
    do_reset();
  endtask

  task automatic test_fetch_wait();
    mem_ready = 1'b0;
    opcode = 6'b000010;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (state !== 4'd0 || ir_write !== 1'b0 || mem_read !== 1'b1) begin
        errs++; $display("FAIL fetch_wait: state=%0d ir_write=%b mem_read=%b want 0 0 1",
                         state, ir_write, mem_read);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    checks++; if (state !== 4'd1) begin errs++; $display("FAIL fetch_wait_exit: got %0d want 1", state); end
    do_reset();
  endtask

  task automatic test_reset_mid_memrd();
    opcode = 6'b100011;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (state !== 4'd3 || mem_read !== 1'b1 || iord !== 1'b1) begin
      errs++; $display("FAIL memrd_wait: state=%0d mem_read=%b iord=%b want 3 1 1", state, mem_read, iord);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || reg_write !== 1'b0 || iord !== 1'b0) begin
      errs++; $display("FAIL mid_reset: state=%0d reg_write=%b iord=%b want 0 0 0", state, reg_write, iord);
    end
    mem_ready = 1'b1;
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (state !== 4'd1) begin errs++; $display("FAIL mid_reset_release: got %0d want 1", state); end
    do_reset();
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    opcode = 6'b100011;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (state !== exp_st[i]) begin
        errs++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i < 5) begin
        checks++; if (aluop !== 2'b00) begin errs++; $display("FAIL lw_aluop[%0d]: got %b want 00", i, aluop); end
        checks++; if (reg_write !== (i == 4) || (i == 4 && mem_to_reg !== 1'b1)) begin
          errs++; $display("FAIL lw_wb[%0d]: reg_write=%b mem_to_reg=%b", i, reg_write, mem_to_reg);
        end
        tick();
      end
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0] exp_st [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0};
    logic       rdy    [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int         writes = 0;
    opcode = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      checks++; if (state !== exp_st[i]) begin
        errs++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (i < 6) begin
        mem_ready = rdy[i];
        if (mem_write === 1'b1) writes++;
        if (exp_st[i] == 4'd5) begin
          checks++; if (iord !== 1'b1) begin errs++; $display("FAIL sw_iord[%0d]: got %b want 1", i, iord); end
        end
        tick();
      end
    end
    checks++; if (writes !== 3) begin errs++; $display("FAIL sw_write_cycles: got %0d want 3", writes); end
    mem_ready = 1'b1;
  endtask

  task automatic test_rtype();
    opcode = 6'b000000;
    jr = 1'b0;
    mem_ready = 1'b1;
    tick();
    tick();
    checks++; if (state !== 4'd6 || aluop !== 2'b10 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
      errs++; $display("FAIL r_exec: state=%0d aluop=%b a=%b b=%b want 6 10 1 00",
                       state, aluop, alu_src_a, alu_src_b);
    end
    tick();
    checks++; if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
      errs++; $display("FAIL r_wb: state=%0d rw=%b rd=%b m2r=%b want 7 1 1 0",
                       state, reg_write, reg_dst, mem_to_reg);
    end
    tick();
    checks++; if (state !== 4'd0) begin errs++; $display("FAIL r_done: got %0d want 0", state); end
  endtask

  task automatic test_jr();
    opcode = 6'b000000;
    jr = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (state !== 4'd12 || pc_src !== 2'b11 || pc_write !== 1'b1 || reg_write !== 1'b0) begin
      errs++; $display("FAIL jr_ret: state=%0d pc_src=%b pw=%b rw=%b want 12 11 1 0",
                       state, pc_src, pc_write, reg_write);
    end
    jr = 1'b0;
    tick();
    checks++; if (state !== 4'd0) begin errs++; $display("FAIL jr_done: got %0d want 0", state); end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic exp_pw);
    opcode = op;
    zero = z;
    tick();
    tick();
    checks++; if (state !== 4'd8 || aluop !== 2'b01 || pc_src !== 2'b01 || pc_write !== exp_pw) begin
      errs++; $display("FAIL branch op=%b z=%b: state=%0d aluop=%b pc_src=%b pw=%b want 8 01 01 %b",
                       op, z, state, aluop, pc_src, pc_write, exp_pw);
    end
    zero = 1'b0;
    tick();
    checks++; if (state !== 4'd0) begin errs++; $display("FAIL branch_done: got %0d want 0", state); end
  endtask

  task automatic test_ori_j();
    opcode = 6'b001101;
    tick();
    tick();
    checks++; if (state !== 4'd9 || aluop !== 2'b11 || alu_src_b !== 2'b10) begin
      errs++; $display("FAIL ori_exec: state=%0d aluop=%b b=%b want 9 11 10", state, aluop, alu_src_b);
    end
    tick();
    checks++; if (state !== 4'd10 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
      errs++; $display("FAIL ori_wb: state=%0d rw=%b rd=%b want 10 1 0", state, reg_write, reg_dst);
    end
    tick();
    opcode = 6'b000010;
    tick();
    tick();
    checks++; if (state !== 4'd11 || pc_src !== 2'b10 || pc_write !== 1'b1) begin
      errs++; $display("FAIL j_jump: state=%0d pc_src=%b pw=%b want 11 10 1", state, pc_src, pc_write);
    end
    tick();
    checks++; if (state !== 4'd0) begin errs++; $display("FAIL j_done: got %0d want 0", state); end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    checks++; if (illegal_op !== 1'b0) begin errs++; $display("FAIL ill_fetch: got %b want 0", illegal_op); end
    tick();
    checks++; if (state !== 4'd1 || illegal_op !== 1'b1) begin
      errs++; $display("FAIL ill_decode: state=%0d illegal_op=%b want 1 1", state, illegal_op);
    end
    tick();
    checks++; if (state !== 4'd0 || illegal_op !== 1'b0) begin
      errs++; $display("FAIL ill_after: state=%0d illegal_op=%b want 0 0", state, illegal_op);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_wait();
    test_reset_mid_memrd();
    test_lw();
    test_sw_wait();
    test_rtype();
    test_jr();
    test_branch(6'b000100, 1'b1, 1'b1);
    test_branch(6'b000101, 1'b1, 1'b0);
    test_branch(6'b000100, 1'b0, 1'b0);
    test_branch(6'b000101, 1'b0, 1'b1);
    test_ori_j();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
